// File: rtl/game_pkg.sv
// Shared pong game types: state encoding, winner codes and default constants.
// Imported by the game sequencer and by the ball, pad and score controllers.
package game_pkg;

  typedef enum logic [1:0] {
    START     = 2'b00,
    PLAY      = 2'b01,
    POINT     = 2'b10,
    GAME_OVER = 2'b11
  } game_state_t;

  localparam logic [1:0]  WIN_NONE = 2'b00;
  localparam logic [1:0]  WIN_P1   = 2'b01;
  localparam logic [1:0]  WIN_P2   = 2'b10;

  localparam logic [10:0] DEF_LEFT_GOAL_X  = 11'd20;
  localparam logic [10:0] DEF_RIGHT_GOAL_X = 11'd1004;
  localparam logic [3:0]  DEF_WIN_SCORE    = 4'd9;
  localparam int          DEF_POINT_TICKS  = 60;

endpackage

// File: rtl/game_state_controller_tick_counter.sv
// Tick-enabled up-counter with synchronous clear and terminal-count flag.
// Saturates at LIMIT so it can never wrap back to zero.
module tick_counter #(
  parameter int LIMIT = 60,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear has priority; otherwise count enabled ticks up to LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/game_state_controller.sv
// Pong game sequencer: goal detection, point pause, winner and restart.
// Optional pause support is built when GAME_PAUSE_EN is defined.
module game_state_controller
  import game_pkg::*;
#(
  parameter logic [10:0] LEFT_GOAL_X  = DEF_LEFT_GOAL_X,
  parameter logic [10:0] RIGHT_GOAL_X = DEF_RIGHT_GOAL_X,
  parameter int          POINT_TICKS  = DEF_POINT_TICKS,
  parameter logic [3:0]  WIN_SCORE    = DEF_WIN_SCORE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic        pause,
  input  logic [10:0] x_ball,
  input  logic [3:0]  player1_score,
  input  logic [3:0]  player2_score,
  output logic [1:0]  state,
  output logic        point_p1,
  output logic        point_p2,
  output logic        serve_dir,
  output logic [1:0]  winner,
  output logic        paused
);

  localparam int CW = $clog2(POINT_TICKS + 1);

  game_state_t state_q, state_d;
  logic        start_q;
  logic        point_p1_q, point_p1_d;
  logic        point_p2_q, point_p2_d;
  logic        serve_dir_q, serve_dir_d;
  logic [1:0]  winner_q, winner_d;
  logic        paused_q;

  logic          start_edge;
  logic          goal_l, goal_r;
  logic          eval_goal;
  logic          point_tick;
  logic          first_tick;
  logic          p1_wins, p2_wins;
  logic          game_end;
  logic [CW-1:0] cnt;
  logic          cnt_tc;

  // Decode the qualifying conditions shared by both FSM processes
  always_comb begin
    start_edge = start & ~start_q;
    goal_l     = (x_ball <= LEFT_GOAL_X);
    goal_r     = (x_ball >= RIGHT_GOAL_X);
    eval_goal  = (state_q == PLAY) & timing_tick & ~paused_q;
    point_tick = (state_q == POINT) & timing_tick;
    first_tick = point_tick & (cnt == '0);
    p1_wins    = (player1_score >= WIN_SCORE);
    p2_wins    = (player2_score >= WIN_SCORE);
    game_end   = first_tick & (p1_wins | p2_wins);
  end

  // Point pause timer: cleared outside POINT, counts ticks inside it
  tick_counter #(
    .LIMIT (POINT_TICKS),
    .W     (CW)
  ) u_point_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != POINT),
    .en    (point_tick),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // State register and start edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      START: begin
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        if (eval_goal && (goal_l || goal_r)) state_d = POINT;
      end
      POINT: begin
        if (game_end)                 state_d = GAME_OVER;
        else if (point_tick && cnt_tc) state_d = PLAY;
      end
      GAME_OVER: begin
        if (start_edge) state_d = START;
      end
      default: state_d = START;
    endcase
  end

  // Output logic: point pulses, serve direction and winner
  always_comb begin
    point_p1_d  = 1'b0;
    point_p2_d  = 1'b0;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    unique case (state_q)
      START: begin
        if (start_edge) begin
          winner_d    = WIN_NONE;
          serve_dir_d = 1'b1;
        end
      end
      PLAY: begin
        if (eval_goal && goal_l) begin
          point_p2_d  = 1'b1;
          serve_dir_d = 1'b0;
        end else if (eval_goal && goal_r) begin
          point_p1_d  = 1'b1;
          serve_dir_d = 1'b1;
        end
      end
      POINT: begin
        if (game_end) winner_d = p1_wins ? WIN_P1 : WIN_P2;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      point_p1_q  <= 1'b0;
      point_p2_q  <= 1'b0;
      serve_dir_q <= 1'b1;
      winner_q    <= WIN_NONE;
    end else begin
      point_p1_q  <= point_p1_d;
      point_p2_q  <= point_p2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
    end
  end

`ifdef GAME_PAUSE_EN
  logic pause_q;
  logic paused_d;

  // Pause toggles on each pause edge while staying in PLAY
  always_comb begin
    paused_d = paused_q;
    if (state_d != PLAY) begin
      paused_d = 1'b0;
    end else if ((state_q == PLAY) && pause && !pause_q) begin
      paused_d = ~paused_q;
    end
  end

  // Pause edge register and paused flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      pause_q  <= pause;
      paused_q <= paused_d;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused_q     = 1'b0;
`endif

  assign state     = state_q;
  assign point_p1  = point_p1_q;
  assign point_p2  = point_p2_q;
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Randomized scoreboard bench for game_state_controller against a
// rule-level reference model; also covers an asynchronous mid-point reset.
module tb_game_state_controller;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int N_STEPS = 15000;

  bit          clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic        start;
  logic        pause;
  logic [10:0] x_ball;
  logic [3:0]  player1_score;
  logic [3:0]  player2_score;
  logic [1:0]  state;
  logic        point_p1;
  logic        point_p2;
  logic        serve_dir;
  logic [1:0]  winner;
  logic        paused;

  always #5 clk = ~clk;

  game_state_controller dut (
    .clk           (clk),
    .rst           (rst),
    .timing_tick   (timing_tick),
    .start         (start),
    .pause         (pause),
    .x_ball        (x_ball),
    .player1_score (player1_score),
    .player2_score (player2_score),
    .state         (state),
    .point_p1      (point_p1),
    .point_p2      (point_p2),
    .serve_dir     (serve_dir),
    .winner        (winner),
    .paused        (paused)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       p1;
    logic       p2;
    logic       sd;
    logic [1:0] win;
    logic       pz;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  // Reference model: game phase 0 start, 1 play, 2 point, 3 game over
  int m_phase;
  int m_ticks;
  bit m_p1, m_p2, m_sd, m_pz;
  int m_win;
  bit m_sprev, m_pprev;
  int sc1, sc2;
  int games = 0;

  function automatic obs_t m_obs();
    obs_t o;
    o.st  = 2'(m_phase);
    o.p1  = m_p1;
    o.p2  = m_p2;
    o.sd  = m_sd;
    o.win = 2'(m_win);
    o.pz  = m_pz;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.st  = state;
    o.p1  = point_p1;
    o.p2  = point_p2;
    o.sd  = serve_dir;
    o.win = winner;
    o.pz  = paused;
    return o;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ticks = 0;
    m_p1 = 0; m_p2 = 0; m_sd = 1; m_pz = 0; m_win = 0;
    m_sprev = 0; m_pprev = 0;
  endtask

  task automatic model_step(input bit tick, input bit st, input bit pz,
                            input int x, input int a, input int b);
    bit se, pe;
    se = st && !m_sprev;
    pe = pz && !m_pprev;
    m_sprev = st;
    m_pprev = pz;
    m_p1 = 0;
    m_p2 = 0;
    case (m_phase)
      0: if (se) begin m_phase = 1; m_win = 0; m_sd = 1; end
      1: begin
        if (tick && !m_pz && x <= 20) begin
          m_p2 = 1; m_sd = 0; m_phase = 2; m_ticks = 0; m_pz = 0;
        end else if (tick && !m_pz && x >= 1004) begin
          m_p1 = 1; m_sd = 1; m_phase = 2; m_ticks = 0; m_pz = 0;
        end else if (PAUSE_EN && pe) begin
          m_pz = !m_pz;
        end
      end
      2: if (tick) begin
        m_ticks++;
        if (m_ticks == 1 && (a >= 9 || b >= 9)) begin
          m_win = (a >= 9) ? 1 : 2;
          m_phase = 3;
          games++;
        end else if (m_ticks == 60) begin
          m_phase = 1;
        end
      end
      default: if (se) m_phase = 0;
    endcase
  endtask

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      fails++;
      if (fails <= 20)
        $display("FAIL %s t=%0t got st=%0d p1=%0d p2=%0d sd=%0d win=%0d pz=%0d expected st=%0d p1=%0d p2=%0d sd=%0d win=%0d pz=%0d",
                 name, $time, act.st, act.p1, act.p2, act.sd, act.win, act.pz,
                 exp.st, exp.p1, exp.p2, exp.sd, exp.win, exp.pz);
    end
  endtask

  // Monitor: every cycle's registered outputs against the next expectation
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("cycle", dut_obs(), e);
    end
  end

  function automatic logic [10:0] pick_x();
    int r;
    r = int'($urandom % 16);
    case (r)
      0:       return 11'($urandom_range(0, 20));
      1:       return 11'd20;
      2:       return 11'd21;
      3:       return 11'd1003;
      4:       return 11'd1004;
      5:       return 11'($urandom_range(1004, 2047));
      default: return 11'($urandom_range(21, 1003));
    endcase
  endfunction

  // One stimulus cycle: drive inputs, advance the model, queue expectation
  task automatic step();
    if (m_phase == 0) begin
      sc1 = 0;
      sc2 = 0;
    end else begin
      if (m_p1 && sc1 < 15) sc1++;
      if (m_p2 && sc2 < 15) sc2++;
    end
    timing_tick   = 1'($urandom % 2);
    start         = (($urandom % 6) == 0);
    pause         = (($urandom % 10) == 0);
    x_ball        = pick_x();
    player1_score = 4'(sc1);
    player2_score = 4'(sc2);
    model_step(timing_tick, start, pause, int'(x_ball), sc1, sc2);
    exp_q.push_back(m_obs());
    @(posedge clk);
    #1;
  endtask

  // Async reset in the middle of a point pause, then synchronous release
  task automatic reset_test();
    obs_t r;
    #5;
    rst = 1'b1;
    #1;
    model_reset();
    r = m_obs();
    cmp("async_reset", dut_obs(), r);
    @(posedge clk);
    #1;
    exp_q.push_back(m_obs());
    rst = 1'b0;
  endtask

  bit rst_done = 1'b0;

  initial begin
    rst = 1'b1;
    timing_tick = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    x_ball = 11'd500;
    player1_score = 4'd0;
    player2_score = 4'd0;
    sc1 = 0;
    sc2 = 0;
    model_reset();
    @(posedge clk);
    #1;
    exp_q.push_back(m_obs());
    rst = 1'b0;
    for (int i = 0; i < N_STEPS; i++) begin
      if (!rst_done && m_phase == 2 && m_ticks == 30) begin
        reset_test();
        rst_done = 1'b1;
      end else begin
        step();
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    checks++;
    if (rst_done && games >= 2) passes++;
    else begin
      fails++;
      $display("FAIL coverage: reset_test=%0d games=%0d, required 1 and >=2", rst_done, games);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level game sequencer for the pong logic; owns the 2-bit `state` bus consumed by the ball, pad and score controllers.
- Detects goals from ball X position and runs the point-pause interval counted in frame ticks.
- Declares the winner from the player scores and restarts the match on a start press.
- Sits inside the game logic, alongside the ball, pad and score controllers.

Parameters:
- LEFT_GOAL_X, 11'd20: ball X at or below this is a point for player 2.
- RIGHT_GOAL_X, 11'd1004: ball X at or above this is a point for player 1.
- POINT_TICKS, 60: timing_tick count spent in POINT before re-serve (1 s at 60 Hz).
- WIN_SCORE, 4'd9: score that ends the match.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- timing_tick, in, 1: one-cycle frame-rate enable.
- start, in, 1: level from a synchronised button; rising edge detected internally.
- pause, in, 1: pause request level (used only with the optional feature).
- x_ball, in, 11: current ball X.
- player1_score, in, 4: score from the score controller.
- player2_score, in, 4: score from the score controller.
- state, out, 2: game state, encoded START=00, PLAY=01, POINT=10, GAME_OVER=11.
- point_p1, out, 1: one-cycle pulse when player 1 scores.
- point_p2, out, 1: one-cycle pulse when player 2 scores.
- serve_dir, out, 1: 0 = serve toward the left, 1 = toward the right.
- winner, out, 2: 00 none, 01 player 1, 10 player 2.

Behaviour:
- Reset (async assert, sync release): state=START, point_p1=point_p2=0, serve_dir=1, winner=00, tick counter=0, start edge register=0.
- start_edge = start & ~start_q. start_q is registered every clk, not gated by timing_tick.
- START:
  - On start_edge, go to PLAY on the next clk.
  - Also clear winner and set serve_dir=1.
- PLAY: evaluated only on a timing_tick cycle.
  - If x_ball <= LEFT_GOAL_X: pulse point_p2 for one clk, set serve_dir=0, go to POINT.
  - Else if x_ball >= RIGHT_GOAL_X: pulse point_p1, set serve_dir=1, go to POINT.
  - The left-goal check takes priority; both cannot be true for legal parameters.
- POINT:
  - Entering POINT clears the counter.
  - Each timing_tick increments the counter.
  - The scores are checked on the first timing_tick after entry, so the score controller has one tick to update. If either score >= WIN_SCORE, set winner (player1 checked first) and go to GAME_OVER.
  - Otherwise, once the counter == POINT_TICKS-1 on a tick, go to PLAY.
  - Counter width is $clog2(POINT_TICKS+1); it never wraps.
- GAME_OVER:
  - Holds until start_edge, then goes to START.
  - winner stays valid until leaving START for PLAY.
- start_edge is ignored in PLAY and POINT.
- A timing_tick coinciding with start_edge in START: start wins and the tick is ignored.
- Output latency: state changes one clk after the qualifying condition.
- point_p* pulses are registered and aligned with the transition into POINT.
- Reset mid-operation: all state returns to reset values immediately.

Optional Feature:
- GAME_PAUSE_EN defined:
  - In PLAY, a pause rising edge freezes the FSM: state stays PLAY, but an internal paused flag masks goal evaluation.
  - A second pause edge resumes.
  - Paused status is also encoded by holding state=START's neighbour... no: it is exposed only through the new `paused` output (1 bit, reset 0).
  - Pause is cleared on entering POINT or GAME_OVER.
- GAME_PAUSE_EN undefined: the pause input is ignored, `paused` is tied 0, and no pause logic is built.

Decomposition:
- Shared package `game_pkg`:
  - typedef enum logic [1:0] game_state_t {START, PLAY, POINT, GAME_OVER}.
  - Default goal X constants and WIN_SCORE.
  - The ball, pad and score controllers import this same typedef.
- One natural sub-module, `tick_counter`: a tick-enabled up-counter with clear, terminal-count flag and parameterised limit.
- The edge detector stays inline.

Test Plan:
- Reset then start pulse: state 00 -> 01 one clk after the rising edge. Holding start high gives no second transition.
- PLAY, x_ball=11'd15 on a tick: point_p2 high exactly 1 clk, serve_dir=0, state=10. Then 60 ticks later state=01.
- PLAY, x_ball=11'd1010 with player1_score driven to 9 on the next tick: winner=01, state=11. A start edge gives state=00, a second start edge gives state=01 with winner=00.
- x_ball=11'd15 with no timing_tick: no transition; the transition occurs on the next tick only.
- Assert rst during POINT with counter=30: all outputs return to reset values asynchronously. After release, a start edge is required to play.
- With GAME_PAUSE_EN, a pause edge in PLAY followed by x_ball=11'd15 on ticks: no point pulse. A second pause edge causes point_p2 on the next tick.
